// File: rtl/seq_detect_param.sv
// Serial pattern detector with a run-time loadable pattern and length.
// Supports overlapping and non-overlapping detection with a saturating match counter.
module seq_detect_param #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  localparam int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             ovl,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state,
  output logic [LEN_W-1:0] fill
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] sr_q, sr_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;

  logic [PAT_W-1:0] shifted;
  logic [PAT_W-1:0] mask;
  logic             loadLegal;
  logic             accept;
  logic             windowFull;
  logic             hit;

  // Only the low len_q bits of the window take part in the comparison.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  always_comb begin
    shifted    = (sr_q << 1) | {{(PAT_W-1){1'b0}}, din};
    loadLegal  = load && (len_in != '0) && (len_in <= LEN_W'(PAT_W));
    accept     = en && (state_q != IDLE);
    windowFull = (state_q == RUN) || ((fill_q + LEN_W'(1)) >= len_q);
    hit        = accept && windowFull && (((shifted ^ pat_q) & mask) == '0);
  end

  // A legal load wins over the bit presented at the same edge; an illegal
  // load falls through to normal bit processing.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    pat_d   = pat_q;
    len_d   = len_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    dout_d  = 1'b0;

    if (loadLegal) begin
      pat_d   = pat_in;
      len_d   = len_in;
      sr_d    = '0;
      fill_d  = '0;
      cnt_d   = '0;
      state_d = FILL;
    end else if (accept) begin
      sr_d = shifted;
      if (hit) begin
        dout_d = 1'b1;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (ovl) begin
          state_d = RUN;
          fill_d  = len_q;
        end else begin
          state_d = FILL;
          fill_d  = '0;
        end
      end else if (state_q == FILL) begin
        fill_d = fill_q + LEN_W'(1);
        if ((fill_q + LEN_W'(1)) == len_q) begin
          state_d = RUN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  assign dout      = dout_q;
  assign match_cnt = cnt_q;
  assign state     = state_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus random traffic checked
// against a bit-history reference model.
module tb_seq_detect_param;

  localparam int PAT_W = 8;
  localparam int CNT_W = 4;
  localparam int LEN_W = $clog2(PAT_W) + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             din = 1'b0;
  logic             load = 1'b0;
  logic [PAT_W-1:0] patIn = '0;
  logic [LEN_W-1:0] lenIn = '0;
  logic             ovl = 1'b0;
  logic             dout;
  logic [CNT_W-1:0] matchCnt;
  logic [1:0]       stateOut;
  logic [LEN_W-1:0] fillOut;

  int assertCount = 0;
  int failCount = 0;

  // Reference model: the bits accepted since the last load or non-overlapping match.
  bit               mLoaded;
  bit               hist[$];
  logic [PAT_W-1:0] mPat;
  int               mLen;
  int               mCnt;
  bit               mDout;

  seq_detect_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .load(load),
    .pat_in(patIn), .len_in(lenIn), .ovl(ovl),
    .dout(dout), .match_cnt(matchCnt), .state(stateOut), .fill(fillOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mLoaded = 1'b0;
    hist.delete();
    mPat = '0;
    mLen = 0;
    mCnt = 0;
    mDout = 1'b0;
  endtask

  task automatic modelEdge(input bit l, input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] li,
                           input bit e, input bit d, input bit o);
    bit legal;
    bit ok;
    legal = l && (int'(li) >= 1) && (int'(li) <= PAT_W);
    mDout = 1'b0;
    if (legal) begin
      mLoaded = 1'b1;
      mPat = p;
      mLen = int'(li);
      hist.delete();
      mCnt = 0;
    end else if (mLoaded && e) begin
      hist.push_back(d);
      if (hist.size() > PAT_W) void'(hist.pop_front());
      if (hist.size() >= mLen) begin
        ok = 1'b1;
        for (int k = 0; k < mLen; k++) begin
          if (hist[hist.size() - 1 - k] != mPat[k]) ok = 1'b0;
        end
        if (ok) begin
          mDout = 1'b1;
          if (mCnt < CNT_MAX) mCnt++;
          if (!o) hist.delete();
        end
      end
    end
  endtask

  function automatic int expState();
    if (!mLoaded) return 0;
    return (hist.size() >= mLen) ? 2 : 1;
  endfunction

  function automatic int expFill();
    if (!mLoaded) return 0;
    return (hist.size() >= mLen) ? mLen : hist.size();
  endfunction

  task automatic compareAll(input string tag);
    checkOutput({tag, ".dout"}, 32'(dout), 32'(mDout));
    checkOutput({tag, ".cnt"}, 32'(matchCnt), 32'(mCnt));
    checkOutput({tag, ".state"}, 32'(stateOut), 32'(expState()));
    checkOutput({tag, ".fill"}, 32'(fillOut), 32'(expFill()));
  endtask

  task automatic applyStimulus(input string tag, input bit l, input logic [PAT_W-1:0] p,
                               input logic [LEN_W-1:0] li, input bit e, input bit d, input bit o);
    load = l; patIn = p; lenIn = li; en = e; din = d; ovl = o;
    @(posedge clk);
    modelEdge(l, p, li, e, d, o);
    #1;
    compareAll(tag);
  endtask

  task automatic sendBit(input string tag, input bit d, input bit o);
    applyStimulus(tag, 1'b0, '0, '0, 1'b1, d, o);
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic pulseReset(input string tag);
    #3;
    rst = 1'b0;
    #1;
    modelReset();
    compareAll(tag);
    checkOutput({tag, ".doutZero"}, 32'(dout), 32'd0);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    int pulses;
    logic [4:0] streamA;
    logic [7:0] streamB;

    modelReset();
    #7;
    compareAll("reset");
    rst = 1'b1;

    for (int i = 0; i < 3; i++) sendBit("idleBits", 1'b1, 1'b1);

    // Pattern 101, overlapping.
    applyStimulus("load101", 1'b1, 8'b101, 4'd3, 1'b0, 1'b0, 1'b1);
    streamA = 5'b10101;
    pulses = 0;
    for (int i = 4; i >= 0; i--) begin
      sendBit("ovlStream", streamA[i], 1'b1);
      if (dout) pulses++;
    end
    checkOutput("ovlCnt", 32'(matchCnt), 32'd2);
    checkOutput("ovlPulses", 32'(pulses), 32'd2);

    // Same stream, non-overlapping.
    applyStimulus("load101b", 1'b1, 8'b101, 4'd3, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 4; i >= 0; i--) begin
      sendBit("novlStream", streamA[i], 1'b0);
      if (dout) pulses++;
    end
    checkOutput("novlCnt", 32'(matchCnt), 32'd1);
    checkOutput("novlPulses", 32'(pulses), 32'd1);
    checkOutput("novlState", 32'(stateOut), 32'd1);
    checkOutput("novlFill", 32'(fillOut), 32'd2);

    // Full-width pattern with an en-low gap in the middle.
    applyStimulus("loadA5", 1'b1, 8'hA5, 4'd8, 1'b0, 1'b0, 1'b1);
    streamB = 8'hA5;
    pulses = 0;
    for (int i = 7; i >= 0; i--) begin
      if (i == 3) begin
        for (int g = 0; g < 2; g++) begin
          applyStimulus("enLow", 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
          checkOutput("enLowDout", 32'(dout), 32'd0);
        end
      end
      sendBit("a5Stream", streamB[i], 1'b1);
      if (dout) pulses++;
    end
    checkOutput("a5LastDout", 32'(dout), 32'd1);
    checkOutput("a5Pulses", 32'(pulses), 32'd1);

    // Length-1 pattern: every 1 matches, counter saturates.
    applyStimulus("loadLen1", 1'b1, 8'h01, 4'd1, 1'b0, 1'b0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      sendBit("len1Stream", 1'b1, 1'b1);
      if (dout) pulses++;
    end
    checkOutput("len1Pulses", 32'(pulses), 32'd20);
    checkOutput("len1Sat", 32'(matchCnt), 32'(CNT_MAX));

    // Illegal load while running: ignored, the bit is still processed.
    applyStimulus("illegalRun", 1'b1, 8'h00, 4'd12, 1'b1, 1'b1, 1'b1);
    checkOutput("illegalRunDout", 32'(dout), 32'd1);

    // Zero-length load from IDLE and a legal load racing a data bit.
    pulseReset("rstA");
    applyStimulus("loadZero", 1'b1, 8'h01, 4'd0, 1'b1, 1'b1, 1'b1);
    checkOutput("loadZeroState", 32'(stateOut), 32'd0);
    for (int i = 0; i < 3; i++) sendBit("zeroBits", 1'b1, 1'b1);
    applyStimulus("loadRace", 1'b1, 8'h01, 4'd1, 1'b1, 1'b1, 1'b1);
    checkOutput("loadRaceFill", 32'(fillOut), 32'd0);
    checkOutput("loadRaceDout", 32'(dout), 32'd0);

    // Reset mid-stream discards progress until a reload.
    applyStimulus("load101c", 1'b1, 8'b101, 4'd3, 1'b0, 1'b0, 1'b1);
    for (int i = 4; i >= 1; i--) sendBit("preRst", streamA[i], 1'b1);
    pulseReset("rstMid");
    pulses = 0;
    for (int i = 4; i >= 0; i--) begin
      sendBit("postRst", streamA[i], 1'b1);
      if (dout) pulses++;
    end
    checkOutput("postRstPulses", 32'(pulses), 32'd0);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        applyStimulus("rndLoad", 1'b1, PAT_W'($urandom), LEN_W'($urandom_range(0, 15)),
                      1'($urandom), 1'($urandom), 1'($urandom));
      end else if (r == 3) begin
        pulseReset("rndRst");
      end else begin
        applyStimulus("rnd", 1'b0, PAT_W'($urandom), '0,
                      ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
